// File: rtl/i2s_tx_if.sv
// Sample-pair handshake bundle for the I2S transmitter.
// The master offers a stereo pair; the slave owns s_ready.
interface i2s_tx_if #(
  parameter int AUDIO_DW = 32
) ();
  logic [AUDIO_DW-1:0] left_in;
  logic [AUDIO_DW-1:0] right_in;
  logic                s_valid;
  logic                s_ready;

  modport master (
    output left_in,
    output right_in,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  left_in,
    input  right_in,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/i2s_tx.sv
// I2S master transmitter: one-pair holding buffer, MSB-first
// serialiser and lrclk generation, all on posedge sclk.
module i2s_tx #(
  parameter int AUDIO_DW = 32
) (
  input  logic    sclk,
  input  logic    rst,
  input  logic    en,
  i2s_tx_if.slave s,
  output logic    lrclk,
  output logic    sdata,
  output logic    underrun,
  output logic    busy
);
  localparam int FW = 2 * AUDIO_DW;
  localparam int CW = $clog2(FW);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [FW-1:0]       sh;
  logic [AUDIO_DW-1:0] buf_l;
  logic [AUDIO_DW-1:0] buf_r;
  logic                buf_full;
  logic                last;
  logic                e0;
  logic                take;

  assign last = (cnt == CW'(FW - 1));
  assign e0   = en & ((state == IDLE) |
                      ((state == RUN) & last));
  assign take = s.s_valid & s.s_ready;

  always_ff @(posedge sclk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      lrclk     <= 1'b0;
      sdata     <= 1'b0;
      underrun  <= 1'b0;
      busy      <= 1'b0;
      buf_full  <= 1'b0;
      buf_l     <= '0;
      buf_r     <= '0;
      s.s_ready <= 1'b1;
    end else begin
      underrun <= 1'b0;
      // A frame edge drains the buffer; that blocks any
      // same-edge transfer because s_ready is low then.
      if (e0 && buf_full) begin
        buf_full  <= 1'b0;
        s.s_ready <= 1'b1;
      end else if (take) begin
        buf_full  <= 1'b1;
        s.s_ready <= 1'b0;
        buf_l     <= s.left_in;
        buf_r     <= s.right_in;
      end

      if (e0) begin
        state    <= RUN;
        busy     <= 1'b1;
        cnt      <= '0;
        lrclk    <= 1'b0;
        sdata    <= sh[FW-1];
        sh       <= buf_full ? {buf_l, buf_r} : '0;
        underrun <= ~buf_full;
      end else begin
        unique case (state)
          IDLE: begin
            busy  <= 1'b0;
            cnt   <= '0;
            sh    <= '0;
            lrclk <= 1'b0;
            sdata <= 1'b0;
          end
          RUN: begin
            sdata <= sh[FW-1];
            sh    <= sh << 1;
            if (last) begin
              state <= DRAIN;
              lrclk <= 1'b0;
            end else begin
              cnt   <= cnt + CW'(1);
              lrclk <= (cnt >= CW'(AUDIO_DW - 1));
            end
          end
          DRAIN: begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            sh    <= '0;
            lrclk <= 1'b0;
            sdata <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx at AUDIO_DW=8 (16-cycle frames).
// Expected bit streams are hand-derived from the stimulus pairs.
module tb_i2s_tx;
  localparam int DW = 8;
  localparam int NP = 4;

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  logic en   = 1'b0;
  logic lrclk, sdata, underrun, busy;

  int ntests = 0;
  int nfail  = 0;

  i2s_tx_if #(.AUDIO_DW(DW)) bus ();

  i2s_tx #(.AUDIO_DW(DW)) dut (
    .sclk     (sclk),
    .rst      (rst),
    .en       (en),
    .s        (bus),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .underrun (underrun),
    .busy     (busy)
  );

  always #5 sclk = ~sclk;

  logic [7:0] pl [NP] = '{8'h5A, 8'hFF, 8'h01, 8'h96};
  logic [7:0] pr [NP] = '{8'hC3, 8'h80, 8'h7E, 8'h69};
  logic       e15 [1:15] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                             1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                             1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  int  idx;
  bit  last_x;

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b",
             tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // Offer the current pair; junk data while the buffer is full.
  task automatic drive();
    if (idx >= NP) begin
      bus.s_valid  = 1'b0;
      bus.left_in  = '0;
      bus.right_in = '0;
    end else if (bus.s_ready) begin
      bus.s_valid  = 1'b1;
      bus.left_in  = pl[idx];
      bus.right_in = pr[idx];
    end else begin
      bus.s_valid  = 1'b1;
      bus.left_in  = 8'($urandom);
      bus.right_in = 8'($urandom);
    end
  endtask

  task automatic step();
    last_x = bus.s_valid && bus.s_ready;
    tick();
    if (last_x) idx++;
    drive();
  endtask

  initial begin
    logic [7:0] cl, cr;
    int ones, xf, lrerr;
    bus.s_valid  = 1'b0;
    bus.left_in  = '0;
    bus.right_in = '0;

    // reset state
    tick();
    rst = 1'b0;
    chk("rst_lrclk", lrclk, 1'b0);
    chk("rst_sdata", sdata, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", bus.s_ready, 1'b1);

    // preload A5/3C, two frames, then drop en
    bus.s_valid  = 1'b1;
    bus.left_in  = 8'hA5;
    bus.right_in = 8'h3C;
    tick();
    bus.s_valid = 1'b0;
    chk("preload_ready", bus.s_ready, 1'b0);
    en = 1'b1;
    tick();
    chk("e0_sdata", sdata, 1'b0);
    chk("e0_lrclk", lrclk, 1'b0);
    chk("e0_underrun", underrun, 1'b0);
    chk("e0_busy", busy, 1'b1);
    chk("e0_ready", bus.s_ready, 1'b1);
    lrerr = 0;
    ones  = 0;
    for (int n = 1; n <= 15; n++) begin
      tick();
      if (sdata !== e15[n]) ones++;
      if (lrclk !== (n >= DW)) lrerr++;
    end
    chkv("f1_bits_err", 32'(ones), 32'd0);
    chkv("f1_lrclk_err", 32'(lrerr), 32'd0);
    tick();
    chk("e16_sdata_r0", sdata, 1'b0);
    chk("e16_lrclk", lrclk, 1'b0);
    chk("e16_underrun", underrun, 1'b1);
    en = 1'b0;
    ones = 0;
    for (int n = 1; n <= 15; n++) begin
      tick();
      if (n == 1) chk("f2_underrun_pulse", underrun, 1'b0);
      if (sdata) ones++;
    end
    chkv("f2_zero_data", 32'(ones), 32'd0);
    tick();
    chk("drain_busy", busy, 1'b1);
    chk("drain_lrclk", lrclk, 1'b0);
    tick();
    chk("idle_busy", busy, 1'b0);
    chk("idle_sdata", sdata, 1'b0);

    // streamed pairs with backpressure
    idx = 0;
    drive();
    step();
    en = 1'b1;
    step();
    chk("st_e0_underrun", underrun, 1'b0);
    chk("st_e0_ready", bus.s_ready, 1'b1);
    for (int f = 0; f < NP; f++) begin
      cl = '0;
      cr = '0;
      xf = 0;
      lrerr = 0;
      for (int n = 1; n <= 16; n++) begin
        step();
        if (last_x) xf++;
        if (n <= DW) cl[DW-n] = sdata;
        else cr[2*DW-n] = sdata;
        if (n < 16 && lrclk !== (n >= DW)) lrerr++;
        if (n == 5 && f < NP - 1)
          chk("st_backpressure", bus.s_ready, 1'b0);
        if (n == 15 && f == NP - 1) en = 1'b0;
      end
      chkv("st_left", 32'(cl), 32'(pl[f]));
      chkv("st_right", 32'(cr), 32'(pr[f]));
      chkv("st_xfers", 32'(xf), (f < NP - 1) ? 32'd1 : 32'd0);
      chkv("st_lrclk_err", 32'(lrerr), 32'd0);
      if (f < NP - 1) chk("st_underrun", underrun, 1'b0);
    end
    chk("st_drain_r0", sdata, 1'b1);
    chk("st_drain_busy", busy, 1'b1);
    step();
    chk("st_idle_busy", busy, 1'b0);
    chk("st_idle_sdata", sdata, 1'b0);

    // empty start, then handshake on a frame edge
    en = 1'b1;
    tick();
    chk("emp_underrun", underrun, 1'b1);
    chk("emp_sdata", sdata, 1'b0);
    ones = 0;
    for (int n = 1; n <= 16; n++) begin
      if (n == 16) begin
        bus.s_valid  = 1'b1;
        bus.left_in  = 8'h81;
        bus.right_in = 8'h42;
      end
      tick();
      if (n == 1) chk("emp_pulse_once", underrun, 1'b0);
      if (n == DW) chk("emp_lrclk_hi", lrclk, 1'b1);
      if (n < 16 && sdata) ones++;
    end
    bus.s_valid = 1'b0;
    chkv("emp_zero_data", 32'(ones), 32'd0);
    chk("hs_e0_underrun", underrun, 1'b1);
    chk("hs_e0_lrclk", lrclk, 1'b0);
    chk("hs_e0_ready", bus.s_ready, 1'b0);
    ones = 0;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (n == DW) chk("hs_ready_held", bus.s_ready, 1'b0);
      if (sdata) ones++;
    end
    chkv("hs_frame_zero", 32'(ones), 32'd0);
    chk("hs_next_underrun", underrun, 1'b0);
    chk("hs_next_ready", bus.s_ready, 1'b1);
    bus.s_valid  = 1'b1;
    bus.left_in  = 8'h55;
    bus.right_in = 8'h0F;
    tick();
    bus.s_valid = 1'b0;
    chk("hs_msb", sdata, 1'b1);
    for (int n = 2; n <= 13; n++) begin
      tick();
      if (n == DW) chk("hs_lsb", sdata, 1'b1);
    end
    chk("pre_rst_lrclk", lrclk, 1'b1);

    // reset at bit 5 of the right half
    rst = 1'b1;
    en  = 1'b0;
    tick();
    chk("mid_rst_lrclk", lrclk, 1'b0);
    chk("mid_rst_sdata", sdata, 1'b0);
    chk("mid_rst_ready", bus.s_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    rst = 1'b0;
    en  = 1'b1;
    tick();
    chk("post_rst_discard", underrun, 1'b1);
    en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
